// File: rtl/rx_frame_assembler_pkg.sv
// Shared constants for the receive framer: FSM encodings, statistics width
// and a saturating-increment helper.
package rx_framer_pkg;

    localparam int CNT_W = 16;

    localparam logic [1:0] ST_HUNT    = 2'd0;
    localparam logic [1:0] ST_LEN     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/rx_frame_assembler_if.sv
// Byte-strobe input side and AXI-Stream output side of the framer, bundled so
// the design sees the slave view and the driver/bench the master view.
interface rx_frame_assembler_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;

    modport slave (
        input  in_data, in_valid, m_axis_tready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport master (
        output in_data, in_valid, m_axis_tready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/rx_frame_assembler_commit_fifo.sv
// Payload FIFO with a tentative write pointer that is either committed
// (making the frame visible to the reader) or rewound (discarding it).
module rx_commit_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
    input  logic              commit_i,
    input  logic              rewind_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o,
    output logic              valid_o,
    output logic              full_o
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [DATA_W:0]    mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_q;
    logic [PTR_W-1:0]   wrTent_q;
    logic [PTR_W-1:0]   wrCommit_q;

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wrTent_q[AW-1:0]] <= {last_i, data_i};
        end
    end

    // Commit is only raised together with the push of the final byte, so it
    // publishes everything up to and including the entry being written now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q       <= '0;
            wrTent_q   <= '0;
            wrCommit_q <= '0;
        end else begin
            if (rewind_i) begin
                wrTent_q <= wrCommit_q;
            end else if (push_i) begin
                wrTent_q <= wrTent_q + 1'b1;
            end
            if (commit_i) begin
                wrCommit_q <= wrTent_q + 1'b1;
            end
            if (pop_i) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

    assign full_o  = (wrTent_q[AW] != rd_q[AW]) && (wrTent_q[AW-1:0] == rd_q[AW-1:0]);
    assign valid_o = (rd_q != wrCommit_q);

    // Gate the read port so the outputs are zero whenever nothing is committed.
    assign data_o = valid_o ? mem_q[rd_q[AW-1:0]][DATA_W-1:0] : '0;
    assign last_o = valid_o ? mem_q[rd_q[AW-1:0]][DATA_W]     : 1'b0;

endmodule

// File: rtl/rx_frame_assembler.sv
// Frame hunter: finds the sync byte, reads the length, buffers the payload and
// releases only complete frames on AXI-Stream; bad frames are dropped and counted.
module rx_frame_assembler
    import rx_framer_pkg::*;
#(
    parameter int          DATA_W       = 8,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hD5,
    parameter int          IDLE_TIMEOUT = 64
) (
    input  logic              aclk,
    input  logic              aresetn,
    rx_frame_assembler_if.slave io,
    output logic [CNT_W-1:0]  frames_ok,
    output logic [CNT_W-1:0]  frames_dropped
);
    localparam int REM_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    logic [1:0]        state_q, state_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [CNT_W-1:0]  ok_q, ok_d;
    logic [CNT_W-1:0]  drop_q, drop_d;

    logic push, commit, rewind, pop;
    logic fifoFull, outValid, timeout, lenBad;

    rx_commit_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk      (aclk),
        .rst_n    (aresetn),
        .push_i   (push),
        .data_i   (io.in_data),
        .last_i   (rem_q == REM_W'(1)),
        .commit_i (commit),
        .rewind_i (rewind),
        .pop_i    (pop),
        .data_o   (io.m_axis_tdata),
        .last_o   (io.m_axis_tlast),
        .valid_o  (outValid),
        .full_o   (fifoFull)
    );

    assign io.m_axis_tvalid = outValid;
    assign pop              = outValid && io.m_axis_tready;

    // A byte arriving in the timeout cycle takes priority over the abort.
    assign timeout = (idle_q == IDLE_W'(IDLE_TIMEOUT)) && !io.in_valid;
    assign lenBad  = (io.in_data == '0) || (32'(io.in_data) > FIFO_DEPTH);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        ok_d    = ok_q;
        drop_d  = drop_q;
        push    = 1'b0;
        commit  = 1'b0;
        rewind  = 1'b0;
        idle_d  = (state_q == ST_HUNT || io.in_valid) ? '0 : idle_q + 1'b1;

        case (state_q)
            ST_HUNT: begin
                if (io.in_valid && io.in_data == DATA_W'(SYNC_BYTE)) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (io.in_valid) begin
                    if (lenBad) begin
                        drop_d  = satInc(drop_q);
                        state_d = ST_HUNT;
                    end else begin
                        rem_d   = REM_W'(io.in_data);
                        state_d = ST_PAYLOAD;
                    end
                end else if (timeout) begin
                    drop_d  = satInc(drop_q);
                    state_d = ST_HUNT;
                end
            end
            ST_PAYLOAD: begin
                if (io.in_valid) begin
                    if (fifoFull) begin
                        rewind  = 1'b1;
                        drop_d  = satInc(drop_q);
                        state_d = ST_HUNT;
                    end else begin
                        push  = 1'b1;
                        rem_d = rem_q - 1'b1;
                        if (rem_q == REM_W'(1)) begin
                            commit  = 1'b1;
                            ok_d    = satInc(ok_q);
                            state_d = ST_HUNT;
                        end
                    end
                end else if (timeout) begin
                    rewind  = 1'b1;
                    drop_d  = satInc(drop_q);
                    state_d = ST_HUNT;
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_HUNT;
            rem_q   <= '0;
            idle_q  <= '0;
            ok_q    <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            idle_q  <= idle_d;
            ok_q    <= ok_d;
            drop_q  <= drop_d;
        end
    end

    assign frames_ok      = ok_q;
    assign frames_dropped = drop_q;

endmodule

// File: tb/tb_rx_frame_assembler.sv
// Directed bench for rx_frame_assembler: good frames, idle timeout, bad length,
// overflow, backpressure and asynchronous reset in the middle of a frame.
module tb_rx_frame_assembler;

    logic        aclk    = 1'b0;
    logic        aresetn = 1'b1;
    logic [15:0] frames_ok;
    logic [15:0] frames_dropped;

    int checks   = 0;
    int failures = 0;

    always #5 aclk = ~aclk;

    rx_frame_assembler_if #(.DATA_W(8)) bus ();

    rx_frame_assembler #(
        .DATA_W       (8),
        .FIFO_DEPTH   (16),
        .SYNC_BYTE    (8'hD5),
        .IDLE_TIMEOUT (64)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .io             (bus.slave),
        .frames_ok      (frames_ok),
        .frames_dropped (frames_dropped)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one byte for exactly one clock; returns just after that edge.
    task automatic applyStimulus(input logic [7:0] b);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(posedge aclk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    task automatic sendFrame3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        applyStimulus(8'hD5);
        applyStimulus(8'h03);
        applyStimulus(a);
        applyStimulus(b);
        applyStimulus(c);
    endtask

    task automatic doReset();
        bus.in_valid      = 1'b0;
        bus.in_data       = 8'h00;
        bus.m_axis_tready = 1'b0;
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    // Checks one output beat with tready held high, then lets it be consumed.
    task automatic expectBeat(input string tag, input logic [7:0] d, input logic l);
        @(negedge aclk);
        checkOutput({tag, "_valid"}, 32'(bus.m_axis_tvalid), 32'd1);
        checkOutput({tag, "_data"},  32'(bus.m_axis_tdata),  32'(d));
        checkOutput({tag, "_last"},  32'(bus.m_axis_tlast),  32'(l));
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         hit;
        int         idx;
        logic       stalled;
        logic [7:0] held;
        logic [7:0] v;
        logic [7:0] expD [6];

        expD = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};

        // Reset values
        doReset();
        checkOutput("rst_ok",    32'(frames_ok),          32'd0);
        checkOutput("rst_drop",  32'(frames_dropped),     32'd0);
        checkOutput("rst_valid", 32'(bus.m_axis_tvalid),  32'd0);
        checkOutput("rst_data",  32'(bus.m_axis_tdata),   32'd0);
        checkOutput("rst_last",  32'(bus.m_axis_tlast),   32'd0);

        // 1: good frame, output latency
        $display("[TB] test 1: good frame");
        bus.m_axis_tready = 1'b1;
        applyStimulus(8'hD5);
        applyStimulus(8'h03);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        @(negedge aclk);
        checkOutput("t1_not_early", 32'(bus.m_axis_tvalid), 32'd0);
        applyStimulus(8'h33);
        expectBeat("t1_b0", 8'h11, 1'b0);
        expectBeat("t1_b1", 8'h22, 1'b0);
        expectBeat("t1_b2", 8'h33, 1'b1);
        @(negedge aclk);
        checkOutput("t1_empty", 32'(bus.m_axis_tvalid), 32'd0);
        checkOutput("t1_ok",    32'(frames_ok),         32'd1);
        checkOutput("t1_drop",  32'(frames_dropped),    32'd0);

        // 2: idle timeout then a good frame
        $display("[TB] test 2: idle timeout");
        doReset();
        bus.m_axis_tready = 1'b1;
        applyStimulus(8'hD5);
        applyStimulus(8'h04);
        applyStimulus(8'hAA);
        applyStimulus(8'hBB);
        hit = -1;
        for (int n = 0; n < 100; n++) begin
            @(posedge aclk);
            #1;
            if (frames_dropped == 16'd1) begin
                hit = n;
                break;
            end
        end
        checkOutput("t2_timeout_window", 32'(hit >= 63 && hit <= 64), 32'd1);
        checkOutput("t2_drop",  32'(frames_dropped),    32'd1);
        checkOutput("t2_valid", 32'(bus.m_axis_tvalid), 32'd0);
        checkOutput("t2_ok",    32'(frames_ok),         32'd0);
        applyStimulus(8'hD5);
        applyStimulus(8'h02);
        applyStimulus(8'h5A);
        applyStimulus(8'h6B);
        expectBeat("t2_b0", 8'h5A, 1'b0);
        expectBeat("t2_b1", 8'h6B, 1'b1);
        checkOutput("t2_ok_after", 32'(frames_ok), 32'd1);

        // 3: zero and oversize length
        $display("[TB] test 3: bad length");
        doReset();
        bus.m_axis_tready = 1'b1;
        applyStimulus(8'hD5);
        applyStimulus(8'h00);
        checkOutput("t3_len0_drop", 32'(frames_dropped), 32'd1);
        applyStimulus(8'hD5);
        applyStimulus(8'h11);
        checkOutput("t3_len17_drop", 32'(frames_dropped),     32'd2);
        checkOutput("t3_valid",      32'(bus.m_axis_tvalid),  32'd0);
        applyStimulus(8'hD5);
        applyStimulus(8'h01);
        applyStimulus(8'h77);
        expectBeat("t3_b0", 8'h77, 1'b1);
        checkOutput("t3_ok", 32'(frames_ok), 32'd1);

        // 4: full FIFO, second frame overflows
        $display("[TB] test 4: overflow");
        doReset();
        applyStimulus(8'hD5);
        applyStimulus(8'h10);
        for (int i = 0; i < 16; i++) begin
            v = 8'hA0 + 8'(i);
            applyStimulus(v);
        end
        checkOutput("t4_ok",    32'(frames_ok),         32'd1);
        checkOutput("t4_valid", 32'(bus.m_axis_tvalid), 32'd1);
        checkOutput("t4_head",  32'(bus.m_axis_tdata),  32'hA0);
        applyStimulus(8'hD5);
        applyStimulus(8'h02);
        checkOutput("t4_len_ok", 32'(frames_dropped), 32'd0);
        applyStimulus(8'h01);
        checkOutput("t4_drop",     32'(frames_dropped), 32'd1);
        checkOutput("t4_ok_still", 32'(frames_ok),      32'd1);
        bus.m_axis_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            v = 8'hA0 + 8'(i);
            expectBeat("t4_drain", v, i == 15);
        end
        @(negedge aclk);
        checkOutput("t4_empty", 32'(bus.m_axis_tvalid), 32'd0);

        // 5: two frames drained with toggling tready
        $display("[TB] test 5: backpressure");
        doReset();
        sendFrame3(8'h31, 8'h32, 8'h33);
        sendFrame3(8'h34, 8'h35, 8'h36);
        idx     = 0;
        stalled = 1'b0;
        held    = 8'h00;
        for (int c = 0; c < 40 && idx < 6; c++) begin
            bus.m_axis_tready = c[0];
            @(negedge aclk);
            if (stalled) begin
                checkOutput("t5_hold_valid", 32'(bus.m_axis_tvalid), 32'd1);
                checkOutput("t5_hold_data",  32'(bus.m_axis_tdata),  32'(held));
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                checkOutput("t5_data", 32'(bus.m_axis_tdata), 32'(expD[idx]));
                checkOutput("t5_last", 32'(bus.m_axis_tlast), 32'(idx == 2 || idx == 5));
                idx++;
                stalled = 1'b0;
            end else if (bus.m_axis_tvalid) begin
                stalled = 1'b1;
                held    = bus.m_axis_tdata;
            end
            @(posedge aclk);
            #1;
        end
        checkOutput("t5_count", 32'(idx),       32'd6);
        checkOutput("t5_ok",    32'(frames_ok), 32'd2);
        bus.m_axis_tready = 1'b1;
        @(negedge aclk);
        checkOutput("t5_empty", 32'(bus.m_axis_tvalid), 32'd0);

        // 6: asynchronous reset in the middle of a payload
        $display("[TB] test 6: reset mid-frame");
        doReset();
        applyStimulus(8'hD5);
        applyStimulus(8'h02);
        applyStimulus(8'hC1);
        applyStimulus(8'hC2);
        checkOutput("t6_pre_valid", 32'(bus.m_axis_tvalid), 32'd1);
        applyStimulus(8'hD5);
        applyStimulus(8'h03);
        applyStimulus(8'hE1);
        #2;
        aresetn = 1'b0;
        #1;
        checkOutput("t6_valid", 32'(bus.m_axis_tvalid), 32'd0);
        checkOutput("t6_data",  32'(bus.m_axis_tdata),  32'd0);
        checkOutput("t6_last",  32'(bus.m_axis_tlast),  32'd0);
        checkOutput("t6_ok",    32'(frames_ok),         32'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        bus.m_axis_tready = 1'b1;
        applyStimulus(8'hD5);
        applyStimulus(8'h02);
        applyStimulus(8'hF1);
        applyStimulus(8'hF2);
        expectBeat("t6_b0", 8'hF1, 1'b0);
        expectBeat("t6_b1", 8'hF2, 1'b1);
        checkOutput("t6_ok_after", 32'(frames_ok), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_frame_assembler.md
# rx_frame_assembler

Parametrised framing stage placed after the Manchester decoder in the receiver chain, running entirely in the decoder's fast clock domain. It hunts for a sync byte, reads a length byte, and collects the payload into a commit/rewind FIFO. Only complete frames are released to an AXI-Stream master with `tlast` on the final byte. Truncated frames (idle timeout), oversize frames and overflowed frames are discarded whole and counted.

## Interface
- `DATA_W`, 8, byte width of input and output data.
- `FIFO_DEPTH`, 16, payload FIFO entries; power of two, ≥4.
- `SYNC_BYTE`, 8'hD5, frame start delimiter.
- `IDLE_TIMEOUT`, 64, consecutive `aclk` cycles without `in_valid` that abort a frame in progress; ≥2.
- `aclk` in 1: single clock for all logic.
- `aresetn` in 1: asynchronous, active-low reset.
- `in_data` in DATA_W: decoded byte.
- `in_valid` in 1: one-cycle strobe per byte; no backpressure upstream.
- `m_axis_tdata` out DATA_W: payload byte.
- `m_axis_tvalid` out 1: output byte available.
- `m_axis_tready` in 1: downstream accept.
- `m_axis_tlast` out 1: final payload byte of a frame.
- `frames_ok` out 16: saturating count of committed frames.
- `frames_dropped` out 16: saturating count of discarded frames.

## Operation
- **Frame format:** `SYNC_BYTE`, then LEN (payload bytes N), then N payload bytes. Only the payload is forwarded.
- **FSM states:** HUNT, LEN, PAYLOAD. Reset state is HUNT.
- **HUNT:** if `in_valid` and `in_data==SYNC_BYTE`, go to LEN. All other bytes are ignored and no counter changes.
- **LEN:** on `in_valid`:
  - If LEN==0 or LEN>FIFO_DEPTH: `frames_dropped`++, go to HUNT.
  - Otherwise: `rem<=LEN`, go to PAYLOAD.
- **PAYLOAD:** on `in_valid`:
  - If free==0: rewind the tentative write pointer to the commit pointer, `frames_dropped`++, go to HUNT.
  - Otherwise: write {rem==1, in_data} at the tentative pointer, increment the tentative pointer, decrement `rem`.
  - If rem==1: commit pointer <= tentative+1, `frames_ok`++, go to HUNT.
- **Free-space rule:** free = FIFO_DEPTH − (wr_tent − rd), computed from the registered `rd`. A pop in the same cycle does not create space.
- **Idle counter:**
  - Clears on `in_valid` and in HUNT.
  - Otherwise increments while in LEN or PAYLOAD.
  - When it reaches IDLE_TIMEOUT: rewind (PAYLOAD only), `frames_dropped`++, go to HUNT.
  - If `in_valid` arrives in the same cycle as the timeout, the byte wins and the timeout does not fire.
- **Pointers:** clog2(FIFO_DEPTH)+1 bits and wrap naturally. Full when the MSBs differ and the lower bits are equal.
- **Output:**
  - `m_axis_tvalid` = (rd != wr_commit).
  - `tdata`/`tlast` are read combinationally from the entry at `rd`.
  - `rd` increments on `tvalid && tready`.
  - Only committed data is ever visible on the output.
- **Counters:** saturate at 16'hFFFF.
- **Reset values:** all outputs 0; pointers 0; `rem`=0; idle counter=0.

## Timing
- **Latency:** the last payload byte is accepted at cycle T. The commit pointer updates at the T edge, so `m_axis_tvalid` rises at T+1 and the first byte of the frame is presented then.
- **AXI-Stream rules:**
  - `tvalid`, `tdata` and `tlast` stay stable until `tready`.
  - `tvalid` never drops without a handshake.
  - Back-to-back frames stream with no gap.
- **Counter timing:** `frames_ok` and `frames_dropped` update at the edge that commits or discards the frame.
- **Mid-operation reset:**
  - Asserting `aresetn` mid-frame or mid-output clears immediately, asynchronously.
  - Committed but unread data is lost.
  - The FSM restarts in HUNT on the first `aclk` edge after deassertion.
- **Boundary cases:**
  - LEN==FIFO_DEPTH into an empty FIFO is accepted and fills it exactly.
  - A sync byte seen in PAYLOAD is treated as payload data.

## Structure
- **Package `rx_framer_pkg`:** FSM state encodings (HUNT/LEN/PAYLOAD as localparams) and the counter width constant (16).
- **Sub-module `rx_commit_fifo`:**
  - Contains the memory, the rd / wr_tent / wr_commit pointers, and free/empty logic.
  - Controls: push, commit, rewind, pop.
- **Top module:** the FSM, `rem`, the idle counter and the statistics counters.

## Test plan
1. **Good frame:** D5, 03, 11, 22, 33 with `tready`=1. Expect 11, 22, 33 out, `tlast` on 33 only, `frames_ok`=1, and `tvalid` first rising 1 cycle after 33 is accepted.
2. **Idle timeout:** D5, 04, AA, BB, then 64 idle cycles. Expect no output, `frames_dropped`=1, FIFO empty. A following good frame is delivered intact.
3. **Bad length:** D5, 00, then D5, 11 (17 > FIFO_DEPTH=16). Expect `frames_dropped`=2, no output, and both sequences return the FSM to HUNT.
4. **Overflow:** `tready`=0. Commit one 16-byte frame, then send D5, 02, 01. Expect the second frame dropped on byte 01, `frames_dropped`=1, and all 16 committed bytes then drain correctly with `tlast` on the 16th.
5. **Backpressure:** two 3-byte frames with `tready` toggling every cycle. Expect 6 bytes in order, `tdata` stable while stalled, and `tlast` on bytes 3 and 6.
6. **Reset mid-frame:** assert `aresetn`=0 during the payload of a frame. Expect all outputs 0 immediately and a subsequent frame received correctly.
